multiword_add_seq: RTL and testbench

Multi-cycle sequencer that adds two WIDTH-bit operands by time-sharing one 4-bit ripple-carry slice over WIDTH/4 cycles, least-significant nibble first. The carry is registered between passes. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades latency for area wherever a full-width adder is not justified.

---
 rtl/multiword_add_seq_pkg.sv | 20 ++
 rtl/multiword_add_seq_add_slice4.sv | 35 +++
 rtl/multiword_add_seq.sv | 182 ++++++++++++++++++
 tb/tb_multiword_add_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the nibble-serial multi-word adder: FSM state
// encoding, the slice width and the pass-count helper.
package multiword_add_seq_pkg;

    // Width of the shared ripple-carry slice in bits.
    localparam int NIBBLE_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice passes needed to cover an operand of the given width.
    function automatic int num_passes(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/multiword_add_seq_add_slice4.sv
// add_slice4: purely combinational 4-bit ripple-carry slice built from a
// chain of full-adder cells. Shared by the sequencer across all passes.
module add_slice4
    import multiword_add_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic fa_a, input logic fa_b, input logic fa_c);
        logic fa_s;
        logic fa_co;
        fa_s  = fa_a ^ fa_b ^ fa_c;
        fa_co = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
        return {fa_co, fa_s};
    endfunction

    logic [NIBBLE_W:0] carry_s;

    // Ripple the carry through the four full-adder cells.
    always_comb begin
        carry_s    = {(NIBBLE_W + 1){1'b0}};
        s4         = {NIBBLE_W{1'b0}};
        carry_s[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            {carry_s[i+1], s4[i]} = full_add(a4[i], b4[i], carry_s[i]);
        end
        co = carry_s[NIBBLE_W];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: adds two WIDTH-bit operands by time-sharing one 4-bit
// ripple-carry slice over WIDTH/4 cycles, least-significant nibble first,
// with valid/ready handshakes on both sides.
// Optional feature macro: ADD_SUB_EN adds a 'sub' port selecting a - b.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N     = num_passes(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic                 carry_r;
    logic [WIDTH-1:0]     sum_r;
    logic                 cout_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 out_valid_r;

    logic                 accept_s;
    logic                 last_pass_s;
    logic [WIDTH-1:0]     b_load_s;
    logic                 carry_load_s;
    logic [NIBBLE_W-1:0]  a_nib_s;
    logic [NIBBLE_W-1:0]  b_nib_s;
    logic [NIBBLE_W-1:0]  slice_sum_s;
    logic                 slice_co_s;
    logic [WIDTH-1:0]     sum_next_s;

    assign accept_s    = in_ready && in_valid;
    assign last_pass_s = (state_r == RUN) && (idx_r == IDX_LAST);

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

    // Next-state logic plus the state-decoded handshake/status outputs.
    always_comb begin
        state_next_s = state_r;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx_r == IDX_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand conditioning on accept: subtraction is a + ~b + 1.
    always_comb begin
        b_load_s     = b;
        carry_load_s = cin;
`ifdef ADD_SUB_EN
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`endif
    end

    // Nibble mux into the slice and demux of its result into the sum image.
    always_comb begin
        a_nib_s    = {NIBBLE_W{1'b0}};
        b_nib_s    = {NIBBLE_W{1'b0}};
        sum_next_s = sum_r;
        for (int p = 0; p < N; p++) begin
            if (idx_r == IDX_W'(p)) begin
                a_nib_s                               = a_r[p*NIBBLE_W +: NIBBLE_W];
                b_nib_s                               = b_r[p*NIBBLE_W +: NIBBLE_W];
                sum_next_s[p*NIBBLE_W +: NIBBLE_W]    = slice_sum_s;
            end else begin
                sum_next_s[p*NIBBLE_W +: NIBBLE_W]    = sum_r[p*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    add_slice4 u_slice (
        .a4 (a_nib_s),
        .b4 (b_nib_s),
        .ci (carry_r),
        .s4 (slice_sum_s),
        .co (slice_co_s)
    );

    // Datapath registers: operand capture on accept, one nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == DONE);
            if (accept_s) begin
                a_r     <= a;
                b_r     <= b_load_s;
                carry_r <= carry_load_s;
                sum_r   <= {WIDTH{1'b0}};
                cout_r  <= 1'b0;
                idx_r   <= {IDX_W{1'b0}};
            end else if (state_r == RUN) begin
                sum_r   <= sum_next_s;
                carry_r <= slice_co_s;
                if (last_pass_s) begin
                    // idx holds at the last pass so it never wraps mid-operation.
                    cout_r <= slice_co_s;
                    idx_r  <= idx_r;
                end else begin
                    cout_r <= cout_r;
                    idx_r  <= idx_r + IDX_W'(1);
                end
            end else begin
                sum_r   <= sum_r;
                carry_r <= carry_r;
                cout_r  <= cout_r;
                idx_r   <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq (WIDTH=16).
// Build with +define+ADD_SUB_EN to exercise subtraction as well.
module tb_multiword_add_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multiword_add_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present operands at a falling edge; returns at the falling edge after accept.
    task automatic start_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic ci, input logic sb);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = ci;
        sub      = sb;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b0;
        sub      = 1'b0;
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
    endtask

    // Wait (bounded) for out_valid, check the result, hold backpressure, then accept it.
    task automatic wait_result(input string tag, input int exp_lat, input logic [WIDTH-1:0] exp_sum,
                               input logic exp_cout, input int hold);
        int cnt;
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(sum), 32'(exp_sum));
            check({tag, "_hold_cout"}, 32'(cout), 32'(exp_cout));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with out_ready held high throughout.
        out_ready = 1'b1;
        start_op("basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        wait_result("basic", 4, 16'h2233, 1'b0, 0);

        // Carry ripples through every nibble.
        start_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result("ripple1", 4, 16'h0000, 1'b1, 0);
        start_op("ripple2", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_result("ripple2", 4, 16'h0000, 1'b1, 0);
        start_op("mixed", 16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_result("mixed", 4, 16'h5556, 1'b0, 0);

        // Backpressure: result held for 3 cycles with out_ready low.
        start_op("bp", 16'hA0F1, 16'h0F1F, 1'b0, 1'b0);
        wait_result("bp", 4, 16'hB010, 1'b0, 3);

        // Reset while idx=2 in RUN discards the operation.
        start_op("rstmid", 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_sum", 32'(sum), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rstmid_no_result", 32'(out_valid), 32'd0);
        end
        start_op("fresh", 16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result("fresh", 4, 16'h0002, 1'b0, 0);

        // New operands pulsed during RUN must be ignored.
        start_op("ignore", 16'h1111, 16'h2222, 1'b0, 1'b0);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("ignore", 3, 16'h3333, 1'b0, 0);

`ifdef ADD_SUB_EN
        // Subtraction: cout=1 means no borrow; cin is ignored.
        start_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_result("sub_neg", 4, 16'hFFFE, 1'b0, 0);
        start_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_result("sub_pos", 4, 16'h0002, 1'b1, 0);
        start_op("sub_add", 16'h0007, 16'h0005, 1'b1, 1'b0);
        wait_result("sub_add", 4, 16'h000D, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
